// File: rtl/dynamic_branch_predictor_pkg.sv
// Shared types and helpers for the dynamic branch predictor: BTB entry layout,
// counter constants and PC field extraction.
package dynamic_branch_predictor_pkg;

  localparam int TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  // Weakly taken: MSB set, all lower bits clear.
  function automatic logic [3:0] ctr_weak_taken(int cb);
    return 4'(1 << (cb - 1));
  endfunction

  function automatic logic [3:0] ctr_strong(int cb);
    return 4'((1 << cb) - 1);
  endfunction

  function automatic logic [31:0] pc_idx(logic [31:0] pc, int idx_bits);
    return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_tag(logic [31:0] pc, int idx_bits, int tag_bits);
    return (pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/dynamic_branch_predictor_if.sv
// Fetch-side lookup and decode-side training signals of the branch predictor,
// plus debug taps (counter at the current lookup index, global history).
interface dynamic_branch_predictor_if #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 2,
  parameter int GHR_W = 4
);
  // Fetch lookup is a pure combinational query with no handshake. Training is a
  // valid-only transfer: iUpdateEnD high means the decode fields are valid and
  // are consumed on that rising edge; the predictor can always accept (no ready).
  logic [31:0]      iPCF;
  logic             oPredictTakenF;
  logic [31:0]      oPredictTargetF;
  logic             oHitF;
  logic [IDX_W-1:0] oPhtIndexF;

  logic             iUpdateEnD;
  logic [31:0]      iPCD;
  logic [IDX_W-1:0] iPhtIndexD;
  logic             iTakenD;
  logic [31:0]      iTargetD;
  logic             iIsJumpD;
  logic             iMispredictD;
  logic [31:0]      oMispredictCount;

  logic [CNT_W-1:0] dbg_counter;
  logic [GHR_W-1:0] dbg_ghr;

  modport master (
    output iPCF, iUpdateEnD, iPCD, iPhtIndexD, iTakenD, iTargetD, iIsJumpD, iMispredictD,
    input  oPredictTakenF, oPredictTargetF, oHitF, oPhtIndexF, oMispredictCount,
    input  dbg_counter, dbg_ghr
  );

  modport slave (
    input  iPCF, iUpdateEnD, iPCD, iPhtIndexD, iTakenD, iTargetD, iIsJumpD, iMispredictD,
    output oPredictTakenF, oPredictTargetF, oHitF, oPhtIndexF, oMispredictCount,
    output dbg_counter, dbg_ghr
  );
endinterface

// File: rtl/dynamic_branch_predictor_bp_sat_counter.sv
// Combinational next value of a saturating up/down counter with a force-to-max input.
module bp_sat_counter #(
  parameter int COUNTER_BITS = 2
) (
  input  logic [COUNTER_BITS-1:0] count_i,
  input  logic                    taken_i,
  input  logic                    force_max_i,
  output logic [COUNTER_BITS-1:0] count_o
);
  localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;

  always_comb begin
    count_o = count_i;
    if (force_max_i) begin
      count_o = CNT_MAX;
    end else if (taken_i) begin
      if (count_i != CNT_MAX) count_o = count_i + COUNTER_BITS'(1);
    end else begin
      if (count_i != '0) count_o = count_i - COUNTER_BITS'(1);
    end
  end
endmodule

// File: rtl/dynamic_branch_predictor.sv
// Direct-mapped BTB plus saturating-counter table; combinational lookup, trained from decode.
// Optional gshare indexing of the counter table is enabled with the GSHARE_EN macro.
module dynamic_branch_predictor
  import dynamic_branch_predictor_pkg::*;
#(
  parameter int ENTRIES      = 64,
  parameter int COUNTER_BITS = 2,
  parameter int TAG_BITS     = 8,
  parameter int GHR_BITS     = 4
) (
  input logic                      iClk,
  input logic                      iRst,
  dynamic_branch_predictor_if.slave bp
);
  localparam int IDX = $clog2(ENTRIES);
  localparam logic [COUNTER_BITS-1:0] CTR_WEAK = COUNTER_BITS'(ctr_weak_taken(COUNTER_BITS));
  localparam logic [COUNTER_BITS-1:0] CTR_MAX  = COUNTER_BITS'(ctr_strong(COUNTER_BITS));

  btb_entry_t              btb_q [ENTRIES];
  btb_entry_t              btb_d [ENTRIES];
  logic [COUNTER_BITS-1:0] cnt_q [ENTRIES];
  logic [COUNTER_BITS-1:0] cnt_d [ENTRIES];
  logic [31:0]             miss_cnt_q, miss_cnt_d;

  logic [IDX-1:0]       fetch_idx, pht_idx, upd_idx;
  logic [TAG_MAX_W-1:0] fetch_tag, upd_tag;
  btb_entry_t           fetch_entry;
  logic                 fetch_hit, upd_hit;
  logic [COUNTER_BITS-1:0] sat_next;

  assign fetch_idx   = IDX'(pc_idx(bp.iPCF, IDX));
  assign fetch_tag   = TAG_MAX_W'(pc_tag(bp.iPCF, IDX, TAG_BITS));
  assign fetch_entry = btb_q[fetch_idx];
  assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == fetch_tag) && !iRst;

`ifdef GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  // Only conditional outcomes enter the history; jumps carry no information.
  always_comb begin
    ghr_d = ghr_q;
    if (bp.iUpdateEnD && !bp.iIsJumpD) ghr_d = GHR_BITS'({ghr_q, bp.iTakenD});
  end

  always_ff @(posedge iClk) begin
    if (iRst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end

  assign pht_idx    = fetch_idx ^ IDX'(ghr_q);
  assign bp.dbg_ghr = ghr_q;
`else
  assign pht_idx    = fetch_idx;
  assign bp.dbg_ghr = GHR_BITS'(0);
`endif

  assign bp.oPhtIndexF      = pht_idx;
  assign bp.oHitF           = fetch_hit;
  assign bp.oPredictTakenF  = fetch_hit && cnt_q[pht_idx][COUNTER_BITS-1];
  assign bp.oPredictTargetF = fetch_hit ? fetch_entry.target : 32'd0;
  assign bp.dbg_counter     = cnt_q[pht_idx];
  assign bp.oMispredictCount = miss_cnt_q;

  // Training side: BTB is addressed by the decode PC, the counter by the carried index.
  assign upd_idx = IDX'(pc_idx(bp.iPCD, IDX));
  assign upd_tag = TAG_MAX_W'(pc_tag(bp.iPCD, IDX, TAG_BITS));
  assign upd_hit = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == upd_tag);

  bp_sat_counter #(.COUNTER_BITS(COUNTER_BITS)) u_sat_counter (
    .count_i     (cnt_q[bp.iPhtIndexD]),
    .taken_i     (bp.iTakenD),
    .force_max_i (bp.iIsJumpD),
    .count_o     (sat_next)
  );

  always_comb begin
    btb_d      = btb_q;
    cnt_d      = cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bp.iUpdateEnD) begin
      if (upd_hit) begin
        btb_d[upd_idx].target = bp.iTargetD;
        cnt_d[bp.iPhtIndexD]  = sat_next;
      end else if (bp.iTakenD) begin
        btb_d[upd_idx].valid  = 1'b1;
        btb_d[upd_idx].tag    = upd_tag;
        btb_d[upd_idx].target = bp.iTargetD;
        cnt_d[bp.iPhtIndexD]  = bp.iIsJumpD ? CTR_MAX : CTR_WEAK;
      end
      if (bp.iMispredictD && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Reset clears only valid bits and counters; tags and targets of invalid entries never matter.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i].valid <= 1'b0;
        cnt_q[i]       <= '0;
      end
      miss_cnt_q <= '0;
    end else begin
      btb_q      <= btb_d;
      cnt_q      <= cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule
